// File: rtl/button_pulse_conditioner_pkg.sv
// Shared constants for the timer's button front end: clock rate, default debounce/repeat
// timings, button channel indices and the hold-to-repeat state encoding.
package button_pulse_conditioner_pkg;

    localparam int CLK_HZ              = 100_000_000;
    localparam int NUM_BTN             = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 20_000_000;

    localparam int BTN_START  = 0;
    localparam int BTN_STOP   = 1;
    localparam int BTN_DELETE = 2;
    localparam int BTN_SEC    = 3;
    localparam int BTN_MIN    = 4;

    localparam int DEF_REPEAT_MASK = (1 << BTN_SEC) | (1 << BTN_MIN);

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Counters only ever hold 0 .. terminal-1, so clog2 of the largest terminal suffices.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/button_pulse_conditioner_channel.sv
// One button channel: 2-FF synchronizer, counter debouncer, registered press/release pulses
// and, when BUTTON_AUTO_REPEAT_EN is defined and REPEAT_EN is set, hold-to-repeat press pulses.
module button_pulse_conditioner_channel
    import button_pulse_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] db_cnt_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;
    logic             level_rise;
    logic             level_fall;
    logic             rpt_fire;

    always_comb begin
        db_cnt_d   = '0;
        level_d    = level_q;
        level_rise = 1'b0;
        level_fall = 1'b0;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d    = sync2_q;
                level_rise = sync2_q;
                level_fall = ~sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
    end

    assign press_d   = level_rise | rpt_fire;
    assign release_d = level_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    generate
`ifdef BUTTON_AUTO_REPEAT_EN
        if (REPEAT_EN) begin : g_repeat
            localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
            localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

            rpt_state_e       state_q;
            logic [CNT_W-1:0] rpt_cnt_q;

            // A falling level wins: the release cycle never carries a repeat pulse.
            assign rpt_fire = ~level_fall &
                              (((state_q == RPT_DELAY)  && (rpt_cnt_q == RD_LAST)) ||
                               ((state_q == RPT_REPEAT) && (rpt_cnt_q == RP_LAST)));

            always_ff @(posedge clk) begin
                if (reset || level_fall) begin
                    state_q   <= RPT_IDLE;
                    rpt_cnt_q <= '0;
                end else begin
                    case (state_q)
                        RPT_IDLE: begin
                            rpt_cnt_q <= '0;
                            if (level_rise) state_q <= RPT_DELAY;
                        end
                        RPT_DELAY: begin
                            if (rpt_cnt_q == RD_LAST) begin
                                state_q   <= RPT_REPEAT;
                                rpt_cnt_q <= '0;
                            end else begin
                                rpt_cnt_q <= rpt_cnt_q + CNT_W'(1);
                            end
                        end
                        RPT_REPEAT: begin
                            if (rpt_cnt_q == RP_LAST) rpt_cnt_q <= '0;
                            else                      rpt_cnt_q <= rpt_cnt_q + CNT_W'(1);
                        end
                        default: begin
                            state_q   <= RPT_IDLE;
                            rpt_cnt_q <= '0;
                        end
                    endcase
                end
            end
        end else begin : g_no_repeat
            assign rpt_fire = 1'b0;
        end
`else
        // Repeat logic is not built; the enable bit has no effect here.
        assign rpt_fire = 1'b0 & REPEAT_EN;
`endif
    endgenerate

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/button_pulse_conditioner.sv
// Conditions the raw timer buttons into clean levels and one-cycle press/release pulses.
// Define BUTTON_AUTO_REPEAT_EN to add hold-to-repeat on channels selected by REPEAT_MASK.
module button_pulse_conditioner
    import button_pulse_conditioner_pkg::*;
#(
    parameter int                     NUM_BUTTONS     = NUM_BTN,
    parameter int                     DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int                     REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int                     REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK     = NUM_BUTTONS'(DEF_REPEAT_MASK)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BUTTONS; gi = gi + 1) begin : g_ch
            button_pulse_conditioner_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD),
                .REPEAT_EN       (REPEAT_MASK[gi])
            ) u_channel (
                .clk         (clk),
                .reset       (reset),
                .btn_raw     (btn_raw[gi]),
                .btn_level   (btn_level[gi]),
                .btn_press   (btn_press[gi]),
                .btn_release (btn_release[gi])
            );
        end
    endgenerate

endmodule
